hazard_sched: RTL and testbench

- Pipeline hazard and scheduling controller for the 5-stage MIPS core.
- Decides, every cycle, whether F/D hold, whether a bubble goes into D/E, and whether D/E/M are flushed on an exception.
- Sequences the multi-cycle mult/div unit with a busy counter.
- Drives the stall/enable lines of the F/D pipeline registers and the clr inputs of the D/E and E/M pipeline registers.

---
 rtl/hazard_sched_pkg.sv | 25 ++
 rtl/hazard_sched_md_busy_cnt.sv | 63 ++++++
 rtl/hazard_sched.sv | 95 +++++++++
 tb/tb_hazard_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sched_pkg.sv
// Shared definitions for the hazard/scheduling controller of the 5-stage MIPS core.
package hazard_sched_pkg;

   // Encoding of tuse meaning "this source register is not read".
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Default busy lengths of the multi-cycle mult/div unit.
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Why the front end is stalled this cycle (debug visibility only).
   typedef enum logic [1:0] {
      SR_NONE = 2'd0,
      SR_RS   = 2'd1,
      SR_RT   = 2'd2,
      SR_MD   = 2'd3
   } stall_reason_t;

   // Mult/div sequencer states.
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_sched_md_busy_cnt.sv
// Mult/div busy sequencer: IDLE/BUSY FSM plus a down-counter of remaining cycles.
// An operation issued from E in cycle t keeps md_busy high for t+1..t+N.
module md_busy_cnt
   import hazard_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             md_start_E,
   input  logic             md_is_div_E,
   input  logic             exc_M,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_cnt,
   output md_state_t        dbg_state
);

   localparam logic [CNT_W-1:0] MULT_LD = MULT_CYCLES[CNT_W-1:0];
   localparam logic [CNT_W-1:0] DIV_LD  = DIV_CYCLES[CNT_W-1:0];

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_ok;

   // A start that coincides with an exception belongs to a flushed instruction.
   assign start_ok = md_start_E && !exc_M;

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: load on start (also reloads in BUSY), else count down to idle.
   // An exception alone does not stop a running op; it belongs to a committed instruction.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (start_ok) begin
         state_d = MD_BUSY;
         cnt_d   = md_is_div_E ? DIV_LD : MULT_LD;
      end else if (state_q == MD_BUSY) begin
         if (cnt_q == CNT_W'(1)) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   assign md_busy   = (state_q == MD_BUSY);
   assign md_cnt    = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: rtl/hazard_sched.sv
// Hazard and scheduling controller: decides F/D hold, D/E bubble and
// exception flush every cycle, and sequences the mult/div unit.
module hazard_sched
   import hazard_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [1:0]       tuse_rs_D,
   input  logic [1:0]       tuse_rt_D,
   input  logic [4:0]       write_addr_E,
   input  logic             reg_we_E,
   input  logic [1:0]       tnew_E,
   input  logic [4:0]       write_addr_M,
   input  logic             reg_we_M,
   input  logic [1:0]       tnew_M,
   input  logic             md_start_E,
   input  logic             md_is_div_E,
   input  logic             md_use_D,
   input  logic             exc_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             clr_E,
   output logic             clr_M,
   output logic             flush_D,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_cnt,
   output logic [31:0]      perf_stall_cnt,
   output stall_reason_t    dbg_stall_reason,
   output md_state_t        dbg_md_state
);

   logic        hz_rs, hz_rt, hz_md, stall;
   logic [31:0] perf_cnt_q;

   md_busy_cnt #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_md (
      .clk         (clk),
      .reset       (reset),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .exc_M       (exc_M),
      .md_busy     (md_busy),
      .md_cnt      (md_cnt),
      .dbg_state   (dbg_md_state)
   );

   // Source-operand hazards: a producer in E or M whose result arrives later
   // than D needs it. Register 0 and unread operands never stall.
   always_comb begin
      hz_rs = (rs_D != 5'd0) && (tuse_rs_D != TUSE_NONE) &&
              ((reg_we_E && (write_addr_E == rs_D) && (tnew_E > tuse_rs_D)) ||
               (reg_we_M && (write_addr_M == rs_D) && (tnew_M > tuse_rs_D)));
      hz_rt = (rt_D != 5'd0) && (tuse_rt_D != TUSE_NONE) &&
              ((reg_we_E && (write_addr_E == rt_D) && (tnew_E > tuse_rt_D)) ||
               (reg_we_M && (write_addr_M == rt_D) && (tnew_M > tuse_rt_D)));
      hz_md = md_use_D && (md_busy || md_start_E);
   end

   // Flush beats stall so the handler PC gets fetched; everything is quiet in reset.
   always_comb begin
      stall            = (hz_rs || hz_rt || hz_md) && !exc_M && !reset;
      stall_F          = stall;
      stall_D          = stall;
      clr_E            = (stall || exc_M) && !reset;
      clr_M            = exc_M && !reset;
      flush_D          = exc_M && !reset;
      dbg_stall_reason = SR_NONE;
      if (stall) begin
         if (hz_rs)      dbg_stall_reason = SR_RS;
         else if (hz_rt) dbg_stall_reason = SR_RT;
         else            dbg_stall_reason = SR_MD;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cnt_q <= '0;
      end else if (stall && (perf_cnt_q != 32'hFFFF_FFFF)) begin
         perf_cnt_q <= perf_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: reset, data hazards, mult/div sequencing,
// exception flush, asynchronous reset and stall counter saturation.
module tb_hazard_sched;
   import hazard_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_D, rt_D, write_addr_E, write_addr_M;
   logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
   logic        reg_we_E, reg_we_M, md_start_E, md_is_div_E, md_use_D, exc_M;
   logic        stall_F, stall_D, clr_E, clr_M, flush_D, md_busy;
   logic [3:0]  md_cnt;
   logic [31:0] perf_stall_cnt;
   stall_reason_t dbg_stall_reason;
   md_state_t     dbg_md_state;

   int n_checks = 0;
   int n_fails  = 0;
   logic [31:0] exp_perf;

   hazard_sched dut (
      .clk              (clk),
      .reset            (reset),
      .rs_D             (rs_D),
      .rt_D             (rt_D),
      .tuse_rs_D        (tuse_rs_D),
      .tuse_rt_D        (tuse_rt_D),
      .write_addr_E     (write_addr_E),
      .reg_we_E         (reg_we_E),
      .tnew_E           (tnew_E),
      .write_addr_M     (write_addr_M),
      .reg_we_M         (reg_we_M),
      .tnew_M           (tnew_M),
      .md_start_E       (md_start_E),
      .md_is_div_E      (md_is_div_E),
      .md_use_D         (md_use_D),
      .exc_M            (exc_M),
      .stall_F          (stall_F),
      .stall_D          (stall_D),
      .clr_E            (clr_E),
      .clr_M            (clr_M),
      .flush_D          (flush_D),
      .md_busy          (md_busy),
      .md_cnt           (md_cnt),
      .perf_stall_cnt   (perf_stall_cnt),
      .dbg_stall_reason (dbg_stall_reason),
      .dbg_md_state     (dbg_md_state)
   );

   // Clock: period 10, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // A mult/div start while the unit is busy must never be issued.
   always @(negedge clk) begin
      if (!reset && md_busy && md_start_E) begin
         n_checks++;
         n_fails++;
         $display("FAIL md_start_while_busy: md_cnt=%0d required no start", md_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = TUSE_NONE; tuse_rt_D = TUSE_NONE;
      write_addr_E = 5'd0; reg_we_E = 1'b0; tnew_E = 2'd0;
      write_addr_M = 5'd0; reg_we_M = 1'b0; tnew_M = 2'd0;
      md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0; exc_M = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rs_D = 5'd8; tuse_rs_D = 2'd1; write_addr_E = 5'd8; reg_we_E = 1'b1; tnew_E = 2'd2;
      exc_M = 1'b1;
      reset = 1'b1;
      #2;
      n_checks++;
      if ({stall_F, stall_D, clr_E, clr_M, flush_D} !== 5'b0) begin
         n_fails++;
         $display("FAIL reset_ctrl: got %b required 00000", {stall_F, stall_D, clr_E, clr_M, flush_D});
      end
      step();
      n_checks++;
      if (md_busy !== 1'b0 || md_cnt !== 4'd0 || perf_stall_cnt !== 32'd0) begin
         n_fails++;
         $display("FAIL reset_state: busy=%b cnt=%0d perf=%0d required 0/0/0", md_busy, md_cnt, perf_stall_cnt);
      end
      idle_inputs();
      reset = 1'b0;
      exp_perf = 32'd0;
      step();
   endtask

   task automatic test_load_use();
      // lw $8 in E, add using $8 as rs in D
      rs_D = 5'd8; tuse_rs_D = 2'd1; rt_D = 5'd0; tuse_rt_D = TUSE_NONE;
      write_addr_E = 5'd8; reg_we_E = 1'b1; tnew_E = 2'd2;
      #1;
      n_checks++;
      if ({stall_F, stall_D, clr_E, clr_M, flush_D} !== 5'b11100 || dbg_stall_reason !== SR_RS) begin
         n_fails++;
         $display("FAIL load_use_stall: got %b reason %0d required 11100 reason 1",
                  {stall_F, stall_D, clr_E, clr_M, flush_D}, dbg_stall_reason);
      end
      step();
      exp_perf++;
      // lw now in M with tnew_M=1, add still needs rs at tuse 1: forwardable
      reg_we_E = 1'b0; write_addr_E = 5'd0; tnew_E = 2'd0;
      write_addr_M = 5'd8; reg_we_M = 1'b1; tnew_M = 2'd1;
      #1;
      n_checks++;
      if ({stall_F, stall_D, clr_E} !== 3'b000) begin
         n_fails++;
         $display("FAIL load_use_release: got %b required 000", {stall_F, stall_D, clr_E});
      end
      n_checks++;
      if (perf_stall_cnt !== exp_perf) begin
         n_fails++;
         $display("FAIL load_use_perf: got %0d required %0d", perf_stall_cnt, exp_perf);
      end
      // rt needed immediately (tuse 0) from M with tnew_M=1 -> stall on rt
      rs_D = 5'd0; tuse_rs_D = TUSE_NONE; rt_D = 5'd8; tuse_rt_D = 2'd0;
      #1;
      n_checks++;
      if (stall_D !== 1'b1 || clr_E !== 1'b1 || dbg_stall_reason !== SR_RT) begin
         n_fails++;
         $display("FAIL rt_hazard: stall_D=%b clr_E=%b reason %0d required 1 1 2", stall_D, clr_E, dbg_stall_reason);
      end
      step();
      exp_perf++;
      // Boundary: tnew equal to tuse forwards without stalling; tuse 3 never stalls
      idle_inputs();
      rs_D = 5'd9; tuse_rs_D = 2'd1; write_addr_E = 5'd9; reg_we_E = 1'b1; tnew_E = 2'd1;
      rt_D = 5'd9; tuse_rt_D = TUSE_NONE;
      #1;
      n_checks++;
      if (stall_F !== 1'b0) begin
         n_fails++;
         $display("FAIL tnew_eq_tuse: stall_F=%b required 0", stall_F);
      end
      // Same producer but write enable low
      tnew_E = 2'd2; reg_we_E = 1'b0;
      #1;
      n_checks++;
      if (stall_F !== 1'b0) begin
         n_fails++;
         $display("FAIL no_we: stall_F=%b required 0", stall_F);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_reg0();
      rs_D = 5'd0; tuse_rs_D = 2'd1; write_addr_E = 5'd0; reg_we_E = 1'b1; tnew_E = 2'd2;
      #1;
      n_checks++;
      if ({stall_F, stall_D, clr_E} !== 3'b000) begin
         n_fails++;
         $display("FAIL reg0_stall: got %b required 000", {stall_F, stall_D, clr_E});
      end
      step();
      n_checks++;
      if (perf_stall_cnt !== exp_perf) begin
         n_fails++;
         $display("FAIL reg0_perf: got %0d required %0d", perf_stall_cnt, exp_perf);
      end
      idle_inputs();
   endtask

   task automatic test_mult();
      md_start_E = 1'b1; md_is_div_E = 1'b0; md_use_D = 1'b1;
      #1;
      n_checks++;
      if (stall_F !== 1'b1 || md_busy !== 1'b0 || dbg_stall_reason !== SR_MD) begin
         n_fails++;
         $display("FAIL mult_issue: stall=%b busy=%b reason %0d required 1 0 3", stall_F, md_busy, dbg_stall_reason);
      end
      step();
      md_start_E = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         n_checks++;
         if (md_busy !== 1'b1 || md_cnt !== 4'(6 - k) || stall_D !== 1'b1) begin
            n_fails++;
            $display("FAIL mult_busy_%0d: busy=%b cnt=%0d stall=%b required 1 %0d 1", k, md_busy, md_cnt, stall_D, 6 - k);
         end
         step();
      end
      n_checks++;
      if (md_busy !== 1'b0 || md_cnt !== 4'd0 || stall_D !== 1'b0) begin
         n_fails++;
         $display("FAIL mult_done: busy=%b cnt=%0d stall=%b required 0 0 0", md_busy, md_cnt, stall_D);
      end
      exp_perf += 32'd6;
      n_checks++;
      if (perf_stall_cnt !== exp_perf) begin
         n_fails++;
         $display("FAIL mult_perf: got %0d required %0d", perf_stall_cnt, exp_perf);
      end
      idle_inputs();
   endtask

   task automatic test_div_exc();
      md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1; exc_M = 1'b1;
      #1;
      n_checks++;
      if ({stall_F, stall_D, clr_E, clr_M, flush_D} !== 5'b00111) begin
         n_fails++;
         $display("FAIL exc_flush: got %b required 00111", {stall_F, stall_D, clr_E, clr_M, flush_D});
      end
      step();
      idle_inputs();
      n_checks++;
      if (md_busy !== 1'b0 || md_cnt !== 4'd0) begin
         n_fails++;
         $display("FAIL div_exc_ignored: busy=%b cnt=%0d required 0 0", md_busy, md_cnt);
      end
      n_checks++;
      if (perf_stall_cnt !== exp_perf) begin
         n_fails++;
         $display("FAIL exc_perf: got %0d required %0d", perf_stall_cnt, exp_perf);
      end
      // Legal div, then run to md_cnt=7
      md_start_E = 1'b1; md_is_div_E = 1'b1;
      step();
      idle_inputs();
      n_checks++;
      if (md_busy !== 1'b1 || md_cnt !== 4'd10) begin
         n_fails++;
         $display("FAIL div_load: busy=%b cnt=%0d required 1 10", md_busy, md_cnt);
      end
      step(); step(); step();
      n_checks++;
      if (md_cnt !== 4'd7) begin
         n_fails++;
         $display("FAIL div_cnt7: got %0d required 7", md_cnt);
      end
      exc_M = 1'b1;
      step();
      exc_M = 1'b0;
      n_checks++;
      if (md_busy !== 1'b1 || md_cnt !== 4'd6) begin
         n_fails++;
         $display("FAIL div_exc_continue: busy=%b cnt=%0d required 1 6", md_busy, md_cnt);
      end
   endtask

   task automatic test_async_reset();
      step(); step();
      n_checks++;
      if (md_cnt !== 4'd4) begin
         n_fails++;
         $display("FAIL pre_reset_cnt: got %0d required 4", md_cnt);
      end
      force dut.perf_cnt_q = 32'd9;
      #1;
      release dut.perf_cnt_q;
      // Live load-use hazard so control outputs are asserted before reset
      rs_D = 5'd8; tuse_rs_D = 2'd1; write_addr_E = 5'd8; reg_we_E = 1'b1; tnew_E = 2'd2;
      #1;
      n_checks++;
      if (stall_F !== 1'b1 || perf_stall_cnt !== 32'd9) begin
         n_fails++;
         $display("FAIL pre_reset_state: stall=%b perf=%0d required 1 9", stall_F, perf_stall_cnt);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (md_busy !== 1'b0 || md_cnt !== 4'd0 || perf_stall_cnt !== 32'd0 ||
          {stall_F, stall_D, clr_E, clr_M, flush_D} !== 5'b0) begin
         n_fails++;
         $display("FAIL async_reset: busy=%b cnt=%0d perf=%0d ctrl=%b required 0 0 0 00000",
                  md_busy, md_cnt, perf_stall_cnt, {stall_F, stall_D, clr_E, clr_M, flush_D});
      end
      step();
      reset = 1'b0;
      idle_inputs();
      exp_perf = 32'd0;
      step();
   endtask

   task automatic test_saturation();
      force dut.perf_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.perf_cnt_q;
      rs_D = 5'd8; tuse_rs_D = 2'd1; write_addr_E = 5'd8; reg_we_E = 1'b1; tnew_E = 2'd2;
      step(); step(); step();
      n_checks++;
      if (perf_stall_cnt !== 32'hFFFF_FFFF || stall_F !== 1'b1) begin
         n_fails++;
         $display("FAIL saturation: perf=%h stall=%b required ffffffff 1", perf_stall_cnt, stall_F);
      end
      idle_inputs();
      step();
   endtask

   initial begin
      reset = 1'b1;
      exp_perf = 32'd0;
      idle_inputs();
      test_reset();
      test_load_use();
      test_reg0();
      test_mult();
      test_div_exc();
      test_async_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
